// File: rtl/ddr3_dq_rx_delay_trainer_if.sv
`default_nettype none
// ============================================================================
//  Module      : ddr3_dq_rx_delay_trainer_if
//  Description : Lane-side bundle for the DQ/DQS receive delay trainer:
//                training control/status plus the input IOD delay-line
//                controls and read data.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ddr3_dq_rx_delay_trainer_if #(
    parameter int RX_WIDTH = 4
);
    logic                train_start;
    logic [RX_WIDTH-1:0] rx_data_0;
    logic                delay_line_out_of_range_0;
    logic                delay_line_load_0;
    logic                delay_line_move_0;
    logic                delay_line_direction_0;
    logic                train_busy;
    logic                train_done;
    logic                train_fail;
    logic [6:0]          tap_center;
    logic [7:0]          window_width;

    // Controller / IOD side: drives start, read data and end-stop flag
    modport master (
        output train_start, rx_data_0, delay_line_out_of_range_0,
        input  delay_line_load_0, delay_line_move_0, delay_line_direction_0,
        input  train_busy, train_done, train_fail, tap_center, window_width
    );

    // Trainer side
    modport slave (
        input  train_start, rx_data_0, delay_line_out_of_range_0,
        output delay_line_load_0, delay_line_move_0, delay_line_direction_0,
        output train_busy, train_done, train_fail, tap_center, window_width
    );
endinterface
`default_nettype wire

// File: rtl/ddr3_dq_rx_delay_trainer.sv
`default_nettype none
// ============================================================================
//  Module      : ddr3_dq_rx_delay_trainer
//  Description : Read-leveling trainer for one DDR3 input IOD lane. Sweeps the
//                input delay line from tap 0, finds the longest run of taps
//                where every sampled word equals the read pattern, then
//                reloads the line and steps it to the centre of that run.
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr3_dq_rx_delay_trainer #(
    parameter int                  RX_WIDTH   = 4,
    parameter int                  TAP_MAX    = 127,
    parameter int                  SETTLE_CYC = 8,
    parameter int                  SAMPLES    = 16,
    parameter logic [RX_WIDTH-1:0] PATTERN    = 4'b1010,
    parameter int                  MIN_WINDOW = 4
) (
    input  logic                     FAB_CLK,
    input  logic                     RX_SYNC_RST,
    ddr3_dq_rx_delay_trainer_if.slave bus
);

    localparam int c_CNT_MAX = (SETTLE_CYC > SAMPLES) ? SETTLE_CYC : SAMPLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX) + 1;
    localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_SAMPLE_LAST = c_CNT_W'(SAMPLES - 1);
    localparam logic [6:0]         c_TAP_MAX     = 7'(TAP_MAX);
    localparam logic [7:0]         c_MIN_WINDOW  = 8'(MIN_WINDOW);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LOAD    = 4'd1,
        S_SETTLE  = 4'd2,
        S_SAMPLE  = 4'd3,
        S_EVAL    = 4'd4,
        S_STEP    = 4'd5,
        S_CALC    = 4'd6,
        S_RELOAD  = 4'd7,
        S_CSETTLE = 4'd8,
        S_CMOVE   = 4'd9,
        S_FINISH  = 4'd10
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [6:0]           r_tap;
    logic                 r_all_ok;
    logic                 r_run_open;
    logic [6:0]           r_run_start;
    logic [7:0]           r_run_len;
    logic [6:0]           r_best_start;
    logic [7:0]           r_best_len;
    logic [6:0]           r_target;
    logic [6:0]           r_move_cnt;
    logic                 r_load;
    logic                 r_move;
    logic                 r_dir;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_fail;
    logic [6:0]           r_tap_center;
    logic [7:0]           r_window_width;

    // Run bookkeeping for the tap being evaluated. The candidate is the run
    // that would be closed this cycle: the old run on a failing tap, or the
    // extended/new run when the sweep ends on a passing tap.
    logic                 w_match;
    logic                 w_sweep_end;
    logic [7:0]           w_run_len_nxt;
    logic                 w_cand_valid;
    logic [7:0]           w_cand_len;
    logic [6:0]           w_cand_start;
    logic                 w_take_best;
    logic [6:0]           w_center;

    assign w_match       = (bus.rx_data_0 == PATTERN);
    assign w_sweep_end   = (r_tap == c_TAP_MAX) || bus.delay_line_out_of_range_0;
    assign w_run_len_nxt = r_run_open ? (r_run_len + 8'd1) : 8'd1;
    assign w_cand_valid  = r_all_ok | r_run_open;
    assign w_cand_len    = r_all_ok ? w_run_len_nxt : r_run_len;
    assign w_cand_start  = (r_all_ok && !r_run_open) ? r_tap : r_run_start;
    // Strict compare: an equally long later window never displaces the first
    assign w_take_best   = (!r_all_ok || w_sweep_end) && w_cand_valid &&
                           (w_cand_len > r_best_len);
    assign w_center      = r_best_start + 7'((r_best_len - 8'd1) >> 1);

    assign bus.delay_line_load_0      = r_load;
    assign bus.delay_line_move_0      = r_move;
    assign bus.delay_line_direction_0 = r_dir;
    assign bus.train_busy             = r_busy;
    assign bus.train_done             = r_done;
    assign bus.train_fail             = r_fail;
    assign bus.tap_center             = r_tap_center;
    assign bus.window_width           = r_window_width;

    // Training sequencer: sweep, window tracking, centring; all outputs registered
    always_ff @(posedge FAB_CLK) begin
        if (RX_SYNC_RST) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_tap          <= '0;
            r_all_ok       <= 1'b0;
            r_run_open     <= 1'b0;
            r_run_start    <= '0;
            r_run_len      <= '0;
            r_best_start   <= '0;
            r_best_len     <= '0;
            r_target       <= '0;
            r_move_cnt     <= '0;
            r_load         <= 1'b0;
            r_move         <= 1'b0;
            r_dir          <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_fail         <= 1'b0;
            r_tap_center   <= '0;
            r_window_width <= '0;
        end else begin
            r_load <= 1'b0;
            r_move <= 1'b0;
            r_dir  <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (bus.train_start) begin
                        r_state        <= S_LOAD;
                        r_busy         <= 1'b1;
                        r_done         <= 1'b0;
                        r_fail         <= 1'b0;
                        r_tap          <= '0;
                        r_cnt          <= '0;
                        r_run_open     <= 1'b0;
                        r_run_start    <= '0;
                        r_run_len      <= '0;
                        r_best_start   <= '0;
                        r_best_len     <= '0;
                        r_tap_center   <= '0;
                        r_window_width <= '0;
                    end
                end
                S_LOAD: begin
                    r_load  <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_cnt == c_SETTLE_LAST) begin
                        r_cnt    <= '0;
                        r_all_ok <= 1'b1;
                        r_state  <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    r_all_ok <= r_all_ok & w_match;
                    if (r_cnt == c_SAMPLE_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_EVAL;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_EVAL: begin
                    r_run_open  <= r_all_ok && !w_sweep_end;
                    r_run_len   <= r_all_ok ? w_run_len_nxt : 8'd0;
                    r_run_start <= w_cand_start;
                    if (w_take_best) begin
                        r_best_start <= w_cand_start;
                        r_best_len   <= w_cand_len;
                    end
                    r_state <= w_sweep_end ? S_CALC : S_STEP;
                end
                S_STEP: begin
                    r_move  <= 1'b1;
                    r_tap   <= r_tap + 7'd1;
                    r_state <= S_SETTLE;
                end
                S_CALC: begin
                    r_window_width <= r_best_len;
                    if (r_best_len < c_MIN_WINDOW) begin
                        r_fail   <= 1'b1;
                        r_target <= '0;
                    end else begin
                        r_target <= w_center;
                    end
                    r_state <= S_RELOAD;
                end
                S_RELOAD: begin
                    r_load     <= 1'b1;
                    r_move_cnt <= '0;
                    r_cnt      <= '0;
                    r_state    <= (r_target == 7'd0) ? S_CSETTLE : S_CMOVE;
                end
                S_CMOVE: begin
                    // Idle one cycle after the reload pulse and after every move
                    if (!r_load && !r_move) begin
                        if (bus.delay_line_out_of_range_0) begin
                            r_fail  <= 1'b1;
                            r_state <= S_CSETTLE;
                        end else begin
                            r_move     <= 1'b1;
                            r_move_cnt <= r_move_cnt + 7'd1;
                            if (r_move_cnt == r_target - 7'd1) begin
                                r_state <= S_CSETTLE;
                            end
                        end
                    end
                end
                S_CSETTLE: begin
                    if (r_cnt == c_SETTLE_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_FINISH;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FINISH: begin
                    r_tap_center <= r_fail ? 7'd0 : r_target;
                    r_done       <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ddr3_dq_rx_delay_trainer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ddr3_dq_rx_delay_trainer
//  Description : Self-checking bench for the DQ receive delay trainer. A
//                delay-line model answers LOAD/MOVE pulses and drives read
//                data from a per-tap pass map; a window model predicts the
//                trained result.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr3_dq_rx_delay_trainer;

    localparam logic [3:0] c_PATTERN = 4'b1010;
    localparam int         c_PERIOD  = 8 + 16 + 2;
    localparam int         c_TIMEOUT = 8000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ddr3_dq_rx_delay_trainer_if #(.RX_WIDTH(4)) bus ();

    ddr3_dq_rx_delay_trainer dut (
        .FAB_CLK     (clk),
        .RX_SYNC_RST (rst),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Delay-line / lane environment
    bit pass_map [0:127];
    int oor_tap          = 1000;
    int bad_tap          = -1;
    int dl_tap           = 0;
    int moves_since_load = 0;
    int at_tap           = 0;

    // Observed sequencing (maintained by the monitor)
    int phase       = 0;
    int sweep_moves = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit tap_ok(input int t);
        return (t >= 0) && (t <= 127) && pass_map[t] && (t != bad_tap);
    endfunction

    // Longest strictly-best run of passing taps over the taps the sweep visits
    task automatic model(output int w, output int c, output bit f, output int last);
        int run, rs, bl, bs;
        last = (oor_tap < 127) ? oor_tap : 127;
        run = 0; rs = 0; bl = 0; bs = 0;
        for (int t = 0; t <= last; t++) begin
            if (tap_ok(t)) begin
                if (run == 0) rs = t;
                run++;
                if (run > bl) begin
                    bl = run;
                    bs = rs;
                end
            end else begin
                run = 0;
            end
        end
        w = bl;
        f = (bl < 4);
        c = f ? 0 : bs + (bl - 1) / 2;
    endtask

    task automatic set_map(input int lo, input int hi);
        for (int t = lo; t <= hi; t++) pass_map[t] = 1'b1;
    endtask

    task automatic clear_env();
        for (int t = 0; t < 128; t++) pass_map[t] = 1'b0;
        oor_tap = 1000;
        bad_tap = -1;
    endtask

    // Delay line: moves/reloads on the pulse, data reflects the current tap
    initial begin
        bus.rx_data_0 = ~c_PATTERN;
        bus.delay_line_out_of_range_0 = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.delay_line_load_0 === 1'b1) begin
                dl_tap = 0; moves_since_load = 0; at_tap = 0;
            end else if (bus.delay_line_move_0 === 1'b1) begin
                dl_tap++; moves_since_load++; at_tap = 0;
            end else begin
                at_tap++;
            end
            bus.rx_data_0 = (pass_map[dl_tap > 127 ? 127 : dl_tap] &&
                             !(dl_tap == bad_tap && at_tap == 12)) ? c_PATTERN : ~c_PATTERN;
            bus.delay_line_out_of_range_0 = (dl_tap >= oor_tap);
        end
    end

    // Per-cycle compare: direction, pulse exclusivity, sweep cadence, move gaps
    initial begin
        bit rst_e, prev_busy, prev_move;
        int since;
        prev_busy = 0; prev_move = 0; since = 0;
        forever begin
            @(posedge clk);
            rst_e = rst;
            @(negedge clk);
            chk("direction", bus.delay_line_direction_0, rst_e ? 32'd0 : 32'd1);
            chk("move_load_excl", bus.delay_line_move_0 & bus.delay_line_load_0, 0);
            chk("done_busy_excl", bus.train_done & bus.train_busy, 0);
            if (bus.train_busy && !prev_busy) begin
                phase = 0; sweep_moves = 0;
            end
            since++;
            if (bus.delay_line_load_0) begin
                phase++; since = 0;
            end else if (bus.delay_line_move_0) begin
                if (phase == 1) begin
                    chk("sweep_period", since, c_PERIOD);
                    sweep_moves++;
                end else begin
                    chk("cmove_gap", prev_move, 0);
                end
                since = 0;
            end
            prev_busy = bus.train_busy;
            prev_move = bus.delay_line_move_0;
        end
    end

    task automatic pulse_start();
        @(negedge clk) bus.train_start = 1'b1;
        @(negedge clk) bus.train_start = 1'b0;
    endtask

    task automatic finish_check(input string tag, input int lw, input int lc,
                                input bit lf, input int llast);
        int mw, mc, ml, n;
        bit mf;
        model(mw, mc, mf, ml);
        chk({tag, "_model_width"}, mw, lw);
        chk({tag, "_model_center"}, mc, lc);
        chk({tag, "_model_fail"}, mf, lf);
        chk({tag, "_model_last"}, ml, llast);
        n = 0;
        while (bus.train_done !== 1'b1 && n < c_TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_in_time"}, (n < c_TIMEOUT), 1);
        chk({tag, "_width"}, bus.window_width, mw);
        chk({tag, "_center"}, bus.tap_center, mc);
        chk({tag, "_fail"}, bus.train_fail, mf);
        chk({tag, "_busy_low"}, bus.train_busy, 0);
        chk({tag, "_moves_after_reload"}, moves_since_load, mc);
        chk({tag, "_final_tap"}, dl_tap, mc);
        chk({tag, "_last_swept_tap"}, sweep_moves, ml);
    endtask

    task automatic run_training(input string tag, input int lw, input int lc,
                                input bit lf, input int llast);
        pulse_start();
        chk({tag, "_busy_after_start"}, bus.train_busy, 1);
        chk({tag, "_done_cleared"}, bus.train_done, 0);
        finish_check(tag, lw, lc, lf, llast);
    endtask

    initial begin
        int n;
        bus.train_start = 1'b0;
        clear_env();
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.train_busy, 0);
        chk("rst_done", bus.train_done, 0);
        chk("rst_fail", bus.train_fail, 0);
        chk("rst_load", bus.delay_line_load_0, 0);
        chk("rst_move", bus.delay_line_move_0, 0);
        chk("rst_center", bus.tap_center, 0);
        chk("rst_width", bus.window_width, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        clear_env(); set_map(20, 40);
        run_training("t1", 21, 30, 1'b0, 127);

        clear_env();
        run_training("t2", 0, 0, 1'b1, 127);

        clear_env(); set_map(10, 14); set_map(50, 60);
        run_training("t3a", 11, 55, 1'b0, 127);

        clear_env(); set_map(10, 14); set_map(50, 54);
        run_training("t3b", 5, 12, 1'b0, 127);

        clear_env(); set_map(20, 40); bad_tap = 25;
        run_training("t5", 15, 33, 1'b0, 127);

        clear_env(); set_map(60, 127); oor_tap = 64;
        run_training("t4", 5, 62, 1'b0, 64);

        // Reset in the middle of sampling, then restart with a stray second start
        clear_env(); set_map(20, 40);
        pulse_start();
        n = 0;
        while (bus.delay_line_load_0 !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t6_first_load_seen", (n < 50), 1);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_busy", bus.train_busy, 0);
        chk("t6_rst_done", bus.train_done, 0);
        chk("t6_rst_move", bus.delay_line_move_0, 0);
        chk("t6_rst_load", bus.delay_line_load_0, 0);
        rst = 1'b0;
        @(negedge clk) bus.train_start = 1'b1;
        @(negedge clk) bus.train_start = 1'b0;
        chk("t6_load_not_yet", bus.delay_line_load_0, 0);
        chk("t6_busy", bus.train_busy, 1);
        @(negedge clk);
        chk("t6_load_two_cycles", bus.delay_line_load_0, 1);
        bus.train_start = 1'b1;
        @(negedge clk) bus.train_start = 1'b0;
        repeat (30) @(negedge clk);
        chk("t6_second_start_ignored_loads", phase, 1);
        chk("t6_second_start_ignored_moves", sweep_moves, 1);
        finish_check("t6", 21, 30, 1'b0, 127);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
